// File: rtl/tx_arb_pkg.sv
// Shared types, grant encodings and the round-robin pick for the TX link arbiter.
package tx_arb_pkg;

    localparam int N_REQ = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [N_REQ-1:0] GNT_NONE = 2'b00;
    localparam logic [N_REQ-1:0] GNT_0    = 2'b01;
    localparam logic [N_REQ-1:0] GNT_1    = 2'b10;

    // Winner index among requesters. Only meaningful when at least one
    // request bit is set. On contention the requester that was not served
    // last wins.
    function automatic logic pick_winner(input logic [N_REQ-1:0] req,
                                         input logic             last);
        if (req == 2'b11) begin
            return ~last;
        end
        return req[1];
    endfunction

    function automatic logic [N_REQ-1:0] idx_to_gnt(input logic idx);
        return idx ? GNT_1 : GNT_0;
    endfunction

endpackage

// File: rtl/tx_arb_watchdog.sv
// Loadable saturating up-counter with synchronous clear and a terminal-count
// compare. Used both as the BUSY watchdog and as the GAP turnaround counter.
module tx_arb_watchdog #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_tc_val,
    output logic             o_tc
);

    logic [WIDTH-1:0] r_count;

    // Count up while enabled, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_tc = (r_count == i_tc_val);

endmodule

// File: rtl/tx_link_arb.sv
// Shares one serial RX-facing link between two TX units: round-robin grant,
// combinational data/valid/ready steering, release on a rising finish of the
// granted TX, watchdog abort on a stuck transfer, and a turnaround gap.
module tx_link_arb
    import tx_arb_pkg::*;
#(
    parameter int TIMEOUT    = 64,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] tx_vld_i,
    input  logic [N_REQ-1:0] tx_data_i,
    input  logic [N_REQ-1:0] tx_finish_i,
    input  logic             rx_ready,
    output logic [N_REQ-1:0] rx_ready_o,
    output logic             link_data,
    output logic             link_vld,
    output logic [N_REQ-1:0] gnt,
    output logic             busy,
    output logic [N_REQ-1:0] abort,
    output logic             timeout_err
);

    localparam int WD_W  = $clog2(TIMEOUT);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [WD_W-1:0]  WD_TC  = WD_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_TC = GAP_W'(GAP_CYCLES - 1);

    state_t           r_state;
    logic [N_REQ-1:0] r_gnt;
    logic             r_last;
    logic             r_busy;
    logic [N_REQ-1:0] r_abort;
    logic             r_timeout_err;
    logic [N_REQ-1:0] r_fin_q;

    logic             w_g;
    logic             w_fin_evt;
    logic             w_wd_tc;
    logic             w_gap_tc;

    // The grant is one-hot, so its upper bit is the granted index.
    assign w_g       = r_gnt[1];
    assign w_fin_evt = |(r_gnt & tx_finish_i & ~r_fin_q);

    // Watchdog runs only in BUSY and restarts from zero on every grant.
    tx_arb_watchdog #(.WIDTH(WD_W)) u_watchdog (
        .clk        (clk),
        .rst        (clr),
        .i_clr      (r_state != BUSY),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_en       (r_state == BUSY),
        .i_tc_val   (WD_TC),
        .o_tc       (w_wd_tc)
    );

    // Gap counter runs only in GAP and restarts from zero on every release.
    tx_arb_watchdog #(.WIDTH(GAP_W)) u_gap_cnt (
        .clk        (clk),
        .rst        (clr),
        .i_clr      (r_state != GAP),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_en       (r_state == GAP),
        .i_tc_val   (GAP_TC),
        .o_tc       (w_gap_tc)
    );

    // Registered copy of the finish levels for rising-edge detection.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_fin_q <= '0;
        end else begin
            r_fin_q <= tx_finish_i;
        end
    end

    // Grant FSM with registered grant, busy and abort/timeout pulses.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state       <= IDLE;
            r_gnt         <= GNT_NONE;
            r_last        <= 1'b1;
            r_busy        <= 1'b0;
            r_abort       <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            // NOTE: pulses default low here so any branch that does not raise
            // them yields a single-cycle strobe; later assignments win.
            r_abort       <= '0;
            r_timeout_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (|req) begin
                        r_gnt   <= idx_to_gnt(pick_winner(req, r_last));
                        r_busy  <= 1'b1;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (w_fin_evt) begin
                        r_last  <= w_g;
                        r_gnt   <= GNT_NONE;
                        r_busy  <= 1'b0;
                        r_state <= GAP;
                    end else if (w_wd_tc) begin
                        r_abort       <= r_gnt;
                        r_timeout_err <= 1'b1;
                        r_last        <= w_g;
                        r_gnt         <= GNT_NONE;
                        r_busy        <= 1'b0;
                        r_state       <= GAP;
                    end
                end
                GAP: begin
                    if (w_gap_tc) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt   <= GNT_NONE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Grant is 00 outside BUSY, so masking with it also zeroes the link there.
    assign rx_ready_o  = r_gnt & {N_REQ{rx_ready}};
    assign link_data   = |(r_gnt & tx_data_i);
    assign link_vld    = |(r_gnt & tx_vld_i);
    assign gnt         = r_gnt;
    assign busy        = r_busy;
    assign abort       = r_abort;
    assign timeout_err = r_timeout_err;

endmodule
